// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: drains the receiver holding stage into a small FIFO,
// exposes DATA/STATUS/CTRL registers to the CPU bus and drives a level interrupt.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rx_valid_i,
    input  logic [PAYLOAD_BITS-1:0] rx_data_i,
    output logic                    rx_read_o,
    input  logic [1:0]              addr_i,
    input  logic [7:0]              data_in_i,
    input  logic                    data_write_i,
    input  logic                    data_read_i,
    output logic [7:0]              data_out_o,
    output logic                    irq_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned THR_W = 3;

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       ADDR_DATA   = 2'd0;
    localparam logic [1:0]       ADDR_STATUS = 2'd1;
    localparam logic [1:0]       ADDR_CTRL   = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    state_e                  state_q;
    logic                    rx_read_q;
    logic                    irq_q;

    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;

    logic                    enable_q;
    logic                    drop_q;
    logic                    irq_en_q;
    logic [THR_W-1:0]        thr_q;

    logic                    full_c;
    logic                    nempty_c;
    logic                    ctrl_wr_c;
    logic                    stat_wr_c;
    logic                    flush_c;
    logic                    pop_c;
    logic                    capture_c;
    logic                    push_c;
    logic                    ovf_set_c;
    logic [3:0]              thr_eff_c;
    logic                    irq_cond_c;
    logic                    unused_c;

    assign full_c    = (count_q == DEPTH_C);
    assign nempty_c  = (count_q != '0);
    assign ctrl_wr_c = data_write_i && (addr_i == ADDR_CTRL);
    assign stat_wr_c = data_write_i && (addr_i == ADDR_STATUS);
    assign flush_c   = ctrl_wr_c && data_in_i[6];
    assign pop_c     = data_read_i && (addr_i == ADDR_DATA) && nempty_c;

    // Hold mode leaves the byte in the receiver so its RTS stays deasserted.
    assign capture_c = (state_q == IDLE) && rx_valid_i && enable_q && (!full_c || drop_q);
    assign push_c    = capture_c && !full_c;
    assign ovf_set_c = capture_c && full_c;

    assign thr_eff_c  = (thr_q == '0) ? 4'd1 : 4'(thr_q);
    assign irq_cond_c = irq_en_q && ((4'(count_q) >= thr_eff_c) || overflow_q);

    assign unused_c = data_in_i[7];

    // FIFO pointer/count next state; flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_c) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) tail_d = tail_q + PTR_W'(1);
            if (pop_c)  head_d = head_q + PTR_W'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Sticky overflow: a set in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_set_c)
            overflow_d = 1'b1;
        else if (stat_wr_c && data_in_i[2])
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_c && !flush_c) mem_q[tail_q] <= rx_data_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rx_read_q  <= 1'b0;
            irq_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b1;
            drop_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            thr_q      <= THR_W'(1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (capture_c) begin
                        state_q   <= ACK;
                        rx_read_q <= 1'b1;
                    end else begin
                        rx_read_q <= 1'b0;
                    end
                end
                ACK: begin
                    state_q   <= IDLE;
                    rx_read_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    rx_read_q <= 1'b0;
                end
            endcase

            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_cond_c;

            if (ctrl_wr_c) begin
                enable_q <= data_in_i[0];
                drop_q   <= data_in_i[1];
                irq_en_q <= data_in_i[2];
                thr_q    <= data_in_i[5:3];
            end
        end
    end

    // Register read mux; DATA returns 0 when the FIFO is empty.
    always_comb begin
        data_out_o = 8'h00;
        unique case (addr_i)
            ADDR_DATA:   if (nempty_c) data_out_o = 8'(mem_q[head_q]);
            ADDR_STATUS: data_out_o = {4'(count_q), enable_q, overflow_q, full_c, nempty_c};
            ADDR_CTRL:   data_out_o = {2'b00, thr_q, irq_en_q, drop_q, enable_q};
            default:     data_out_o = 8'h00;
        endcase
    end

    assign rx_read_o = rx_read_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed/randomized bench for uart_rx_ctrl against a queue-based register model.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_read;
    logic [1:0] addr = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic       data_write = 1'b0;
    logic       data_read = 1'b0;
    logic [7:0] data_out;
    logic       irq;

    int checks = 0;
    int failures = 0;

    // Reference model: FIFO contents as a queue plus register fields.
    logic [7:0] mq[$];
    bit         m_en = 1'b1;
    bit         m_drop = 1'b0;
    bit         m_irqen = 1'b0;
    bit         m_ovf = 1'b0;
    logic [2:0] m_thr = 3'd1;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .PAYLOAD_BITS(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_read_o   (rx_read),
        .addr_i      (addr),
        .data_in_i   (data_in),
        .data_write_i(data_write),
        .data_read_i (data_read),
        .data_out_o  (data_out),
        .irq_o       (irq)
    );

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_en = 1'b1;
        m_drop = 1'b0;
        m_irqen = 1'b0;
        m_ovf = 1'b0;
        m_thr = 3'd1;
    endtask

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        int n;
        n = mq.size();
        s[0] = (n != 0);
        s[1] = (n == DEPTH);
        s[2] = m_ovf;
        s[3] = m_en;
        s[7:4] = 4'(n);
        return s;
    endfunction

    function automatic logic [7:0] exp_ctrl();
        return {2'b00, m_thr, m_irqen, m_drop, m_en};
    endfunction

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = data_out;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        peek(a, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic chk_status(input string tag);
        chk_reg(tag, 2'd1, exp_status());
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        data_in = d;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
        if (a == 2'd2) begin
            m_en = d[0];
            m_drop = d[1];
            m_irqen = d[2];
            m_thr = d[5:3];
            if (d[6]) mq.delete();
        end else if (a == 2'd1 && d[2]) begin
            m_ovf = 1'b0;
        end
    endtask

    task automatic rd_data();
        logic [7:0] d;
        logic [7:0] e;
        addr = 2'd0;
        #1;
        d = data_out;
        e = (mq.size() != 0) ? mq[0] : 8'h00;
        chk("data_read", 32'(d), 32'(e));
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic drain();
        while (mq.size() != 0) rd_data();
        chk_status("status_drained");
    endtask

    // Present a byte, expect an ack exactly one cycle later, then let the FSM return to IDLE.
    task automatic send_byte(input logic [7:0] b);
        int lat;
        lat = 0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (rx_read === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("ack_latency", 32'(lat), 32'd1);
        if (lat != 0) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovf = 1'b1;
        end
        rx_valid = 1'b0;
        tick();
        chk("ack_pulse_end", 32'(rx_read), 32'd0);
    endtask

    task automatic wait_ack(input string tag, input int budget, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (rx_read === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [7:0] b;

        // Reset state
        tick();
        tick();
        chk("rst_rx_read", 32'(rx_read), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk_reg("rst_data", 2'd0, 8'h00);
        chk_status("rst_status");
        chk_reg("rst_ctrl", 2'd2, 8'h09);
        chk_reg("rst_reserved", 2'd3, 8'h00);
        resetn = 1'b1;
        tick();

        // Writes to DATA and reserved are ignored
        wr(2'd3, 8'hFF);
        wr(2'd0, 8'h55);
        chk_status("ignored_wr_status");
        chk_reg("ignored_wr_ctrl", 2'd2, exp_ctrl());

        // Single byte
        send_byte(8'hA5);
        chk_status("single_status");
        rd_data();
        chk_status("single_after_pop");

        // Fill and hold
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        chk_status("hold_full_status");
        rx_data = 8'h05;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_no_ack", 32'(rx_read), 32'd0);
        end
        chk_status("hold_status");
        rd_data();
        wait_ack("hold_resume_latency", 3, 1);
        mq.push_back(8'h05);
        rx_valid = 1'b0;
        tick();
        drain();

        // Drop mode overflow
        wr(2'd2, 8'h0B);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        send_byte(8'h77);
        chk_status("drop_ovf_status");
        chk("drop_irq_disabled", 32'(irq), 32'd0);
        wr(2'd1, 8'h04);
        chk_status("ovf_cleared_status");
        drain();

        // Simultaneous push and pop across pointer wrap
        wr(2'd2, 8'h09);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            rx_data = b;
            rx_valid = 1'b1;
            addr = 2'd0;
            #1;
            chk("simul_head", 32'(data_out), 32'(mq[0]));
            data_read = 1'b1;
            tick();
            data_read = 1'b0;
            rx_valid = 1'b0;
            chk("simul_ack", 32'(rx_read), 32'd1);
            void'(mq.pop_front());
            mq.push_back(b);
            tick();
            chk_status("simul_status");
        end
        drain();

        // IRQ threshold
        wr(2'd2, 8'h15);
        send_byte(8'($urandom));
        chk("irq_below_thr", 32'(irq), 32'd0);
        send_byte(8'($urandom));
        chk("irq_at_thr", 32'(irq), 32'd1);
        rd_data();
        chk("irq_pop_lag", 32'(irq), 32'd1);
        tick();
        chk("irq_after_pop", 32'(irq), 32'd0);
        wr(2'd2, 8'h05);
        tick();
        chk("irq_thr0_as_1", 32'(irq), 32'd1);
        drain();
        tick();
        chk("irq_empty", 32'(irq), 32'd0);

        // Flush, including a flush colliding with a push
        wr(2'd2, 8'h09);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        chk_status("pre_flush_status");
        wr(2'd2, 8'h49);
        chk_status("flush_status");
        chk_reg("flush_reads_0", 2'd2, 8'h09);
        rx_data = 8'h3A;
        rx_valid = 1'b1;
        addr = 2'd2;
        data_in = 8'h49;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
        rx_valid = 1'b0;
        chk("flush_push_ack", 32'(rx_read), 32'd1);
        tick();
        chk_status("flush_push_status");
        rd_data();
        chk_status("empty_read_no_change");

        // Disabled: no capture
        wr(2'd2, 8'h08);
        rx_data = 8'h66;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("disabled_no_ack", 32'(rx_read), 32'd0);
        end
        chk_status("disabled_status");

        // Reset during ACK, then re-capture of the byte still held
        rx_valid = 1'b0;
        wr(2'd2, 8'h0D);
        send_byte(8'($urandom));
        chk("pre_reset_irq", 32'(irq), 32'd1);
        rx_data = 8'h3C;
        rx_valid = 1'b1;
        wait_ack("reset_ack_latency", 4, 1);
        resetn = 1'b0;
        tick();
        model_reset();
        chk("reset_ack_rx_read", 32'(rx_read), 32'd0);
        chk("reset_ack_irq", 32'(irq), 32'd0);
        chk_status("reset_ack_status");
        chk_reg("reset_ack_ctrl", 2'd2, 8'h09);
        resetn = 1'b1;
        wait_ack("recapture_latency", 4, 1);
        mq.push_back(8'h3C);
        rx_valid = 1'b0;
        tick();
        rd_data();
        chk_status("final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
